mul_row_sequencer: RTL and testbench
====================================

Name: mul_row_sequencer

Overview:
- Controller that sequences a schoolbook multi-word multiplication through the row accumulator (mul_store) and the word multiplier ahead of it.
- For each word b[j] of operand B it streams every word a[i] of operand A and tags the row with padding j.
- Between rows it waits for the accumulator to finish its flush.
- Sits between the operand BRAMs and the word-multiplier/mul_store pair; pulses done_out when all rows are accumulated.

Parameters:
- REGISTER_SIZE, 32, word width in bits.
- NUM_BITS, 2048, operand width; WORDS = NUM_BITS/REGISTER_SIZE words per operand.
- DESIRED_SIZE, 2080, accumulator width; sizes padding_out.
- READ_LATENCY, 2, operand BRAM read latency in cycles (>=1).

Ports:
- clk_in  input  1  clock
- rst_in  input  1  synchronous active-high reset
- start_in  input  1  begin a multiplication; sampled only in IDLE
- store_ready_in  input  1  accumulator ready (low while it is clearing)
- store_valid_in  input  1  accumulator flush-output valid
- stall_in  input  1  pause issue (only with MUL_SEQ_STALL_EN)
- a_addr_out  output  $clog2(WORDS)  operand A read address
- b_addr_out  output  $clog2(WORDS)  operand B read address
- word_valid_out  output  1  operand data now on BRAM outputs is a valid pair (address issue delayed by READ_LATENCY)
- padding_out  output  $clog2(DESIRED_SIZE)+1  row offset j, aligned with word_valid_out
- busy_out  output  1  high from accepted start until done
- done_out  output  1  one-cycle pulse after the last row flush completes

Behaviour:
- Reset: state IDLE; all address counters 0; the valid delay line cleared.
- Reset: a_addr_out, b_addr_out, word_valid_out, padding_out, busy_out and done_out all 0.
- Reset mid-operation aborts immediately, with identical values.
- IDLE:
  - start_in -> WAIT_READY; i=0, j=0; busy_out=1.
  - start_in while busy is ignored.
- WAIT_READY: hold until store_ready_in=1, then -> ISSUE.
- ISSUE:
  - Each cycle drive a_addr_out=i, b_addr_out=j and push 1 into the valid delay line; i increments.
  - When i==WORDS-1, the issue completes and the state moves -> DRAIN.
  - Issue is contiguous: exactly WORDS issue cycles per row.
- DRAIN: push 0s for READ_LATENCY cycles so the final word emerges; then -> WAIT_FLUSH.
- WAIT_FLUSH:
  - Wait for store_valid_in to rise and then fall (edge detect on a registered copy).
  - On the falling edge: if j==WORDS-1 -> DONE; else j++, i=0, -> WAIT_READY.
- DONE: done_out=1 for one cycle, busy_out=0, -> IDLE. A start_in in this cycle is ignored.
- word_valid_out is the delay-line tap at depth READ_LATENCY.
- padding_out is the j value captured into a parallel delay line, so it is always aligned with word_valid_out.
- Between rows padding_out holds its last value; it is 0 outside operation.
- store_valid_in activity outside WAIT_FLUSH is ignored.
- store_valid_in already high on entering WAIT_FLUSH counts as risen.
- Row count is exactly WORDS; total valid words = WORDS*WORDS.
- Arithmetic: i and j wrap only by explicit reset to 0; no modular overflow is permitted.

Optional Feature:
- Macro MUL_SEQ_STALL_EN.
- Defined:
  - stall_in=1 during ISSUE freezes i and pushes 0 into the valid delay line, producing a bubble; issue resumes at the same i.
  - Stall in the final issue cycle delays the DRAIN entry.
  - stall_in is ignored in other states.
- Undefined: stall_in is unconnected internally (port kept, ignored); issue is strictly contiguous.

Decomposition:
- Package mul_seq_pkg:
  - state enum {IDLE, WAIT_READY, ISSUE, DRAIN, WAIT_FLUSH, DONE};
  - function words_of(num_bits, reg_size);
  - padding width constant.
- Sub-module valid_delay_line:
  - parameterised depth and width; synchronous reset clears all stages;
  - carries {valid, padding} for READ_LATENCY cycles.

Test Plan (REGISTER_SIZE=32, NUM_BITS=128, DESIRED_SIZE=160, READ_LATENCY=2, WORDS=4):
- Basic run:
  - Stimulus: store_ready_in=1, start_in pulse, store model flushes 10 words after each row.
  - Response: 4 rows of 4 valid words; padding 0,1,2,3; a_addr 0..3 each row; b_addr equals row.
  - done_out single pulse after the 4th flush falls; 16 valid words total.
- Latency: first word_valid_out exactly 2 cycles after the first ISSUE cycle with a_addr_out=0; padding_out=0 on that cycle.
- Ready gating: store_ready_in=0 for 20 cycles after start.
  - Response: no address advance and word_valid_out=0 throughout; issue begins the cycle after ready rises.
- Reset mid-row: rst_in during row 2, issue i=1.
  - Response: next cycle all outputs 0, state IDLE.
  - A new start_in yields a fresh run beginning with padding 0.
- Ignored start: start_in held high throughout a run.
  - Response: exactly one done_out pulse; busy_out continuous; no restart until the next start in IDLE.
- Stall (MUL_SEQ_STALL_EN): stall_in=1 for 3 cycles at row 1, i=2.
  - Response: 3 word_valid_out bubbles; words delivered in order i=0..3, still 4 valid words in the row; padding_out=1.

Source files
------------

// File: rtl/mul_row_sequencer_pkg.sv
// Shared types and sizing helpers for the multi-word multiply row sequencer.
package mul_seq_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StWaitReady,
        StIssue,
        StDrain,
        StWaitFlush,
        StDone
    } state_e;

    function automatic int unsigned words_of(input int unsigned num_bits,
                                             input int unsigned reg_size);
        return num_bits / reg_size;
    endfunction

    function automatic int unsigned pad_width(input int unsigned desired_size);
        return $clog2(desired_size) + 1;
    endfunction

    localparam int unsigned DefaultPadWidth = pad_width(2080);

endpackage

// File: rtl/mul_row_sequencer_valid_delay_line.sv
// Fixed-depth shift register carrying {valid, padding} alongside the operand BRAM read latency.
module valid_delay_line #(
    parameter int unsigned Depth = 2,
    parameter int unsigned Width = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [Width-1:0] push_data,
    output logic [Width-1:0] tap_data
);

    logic [Width-1:0] stage_q [Depth];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < Depth; k++) begin
                stage_q[k] <= '0;
            end
        end else begin
            stage_q[0] <= push_data;
            for (int k = 1; k < Depth; k++) begin
                stage_q[k] <= stage_q[k-1];
            end
        end
    end

    assign tap_data = stage_q[Depth-1];

endmodule

// File: rtl/mul_row_sequencer.sv
// Schoolbook multiply row sequencer: streams every A word per B word into the multiplier/row
// accumulator pair. Define MUL_SEQ_STALL_EN to honour stall_in during issue.
module mul_row_sequencer
    import mul_seq_pkg::*;
#(
    parameter int unsigned REGISTER_SIZE = 32,
    parameter int unsigned NUM_BITS      = 2048,
    parameter int unsigned DESIRED_SIZE  = 2080,
    parameter int unsigned READ_LATENCY  = 2,
    localparam int unsigned Words        = words_of(NUM_BITS, REGISTER_SIZE),
    localparam int unsigned AddrWidth    = $clog2(Words),
    localparam int unsigned PadWidth     = pad_width(DESIRED_SIZE)
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 start_in,
    input  logic                 store_ready_in,
    input  logic                 store_valid_in,
    input  logic                 stall_in,
    output logic [AddrWidth-1:0] a_addr_out,
    output logic [AddrWidth-1:0] b_addr_out,
    output logic                 word_valid_out,
    output logic [PadWidth-1:0]  padding_out,
    output logic                 busy_out,
    output logic                 done_out
);

    localparam int unsigned DrainWidth = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

    state_e                state_q, state_d;
    logic [AddrWidth-1:0]  i_q, i_d;
    logic [AddrWidth-1:0]  j_q, j_d;
    logic [DrainWidth-1:0] drain_q, drain_d;
    logic                  flush_seen_q;
    logic [PadWidth-1:0]   pad_hold_q;
    logic [PadWidth-1:0]   pad_src;
    logic                  push_valid;
    logic                  start_ok;
    logic                  stall;
    logic                  line_rst;
    logic [PadWidth:0]     line_in, line_out;

`ifdef MUL_SEQ_STALL_EN
    assign stall = stall_in;
`else
    logic unused_stall;
    assign unused_stall = stall_in;
    assign stall        = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        i_d        = i_q;
        j_d        = j_q;
        drain_d    = drain_q;
        push_valid = 1'b0;
        start_ok   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_in) begin
                    state_d  = StWaitReady;
                    i_d      = '0;
                    j_d      = '0;
                    start_ok = 1'b1;
                end
            end
            StWaitReady: begin
                if (store_ready_in) state_d = StIssue;
            end
            StIssue: begin
                if (!stall) begin
                    push_valid = 1'b1;
                    if (i_q == AddrWidth'(Words - 1)) begin
                        state_d = StDrain;
                        drain_d = '0;
                    end else begin
                        i_d = i_q + AddrWidth'(1);
                    end
                end
            end
            StDrain: begin
                if (drain_q == DrainWidth'(READ_LATENCY - 1)) begin
                    state_d = StWaitFlush;
                end else begin
                    drain_d = drain_q + DrainWidth'(1);
                end
            end
            StWaitFlush: begin
                // Falling edge of the accumulator flush ends the row
                if (flush_seen_q && !store_valid_in) begin
                    if (j_q == AddrWidth'(Words - 1)) begin
                        state_d = StDone;
                    end else begin
                        j_d     = j_q + AddrWidth'(1);
                        i_d     = '0;
                        state_d = StWaitReady;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Padding only advances with a pushed word, so it holds across the inter-row gap
    assign pad_src = (state_q == StIssue) ? PadWidth'(j_q) : pad_hold_q;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q      <= StIdle;
            i_q          <= '0;
            j_q          <= '0;
            drain_q      <= '0;
            flush_seen_q <= 1'b0;
            pad_hold_q   <= '0;
        end else begin
            state_q      <= state_d;
            i_q          <= i_d;
            j_q          <= j_d;
            drain_q      <= drain_d;
            flush_seen_q <= (state_q == StWaitFlush) && store_valid_in;
            pad_hold_q   <= start_ok ? '0 : pad_src;
        end
    end

    assign line_rst = rst_in | start_ok;
    assign line_in  = {push_valid, pad_src};

    valid_delay_line #(
        .Depth (READ_LATENCY),
        .Width (PadWidth + 1)
    ) u_delay_line (
        .clk       (clk_in),
        .rst       (line_rst),
        .push_data (line_in),
        .tap_data  (line_out)
    );

    assign a_addr_out     = i_q;
    assign b_addr_out     = j_q;
    assign busy_out       = state_q inside {StWaitReady, StIssue, StDrain, StWaitFlush};
    assign done_out       = (state_q == StDone);
    assign word_valid_out = line_out[PadWidth];
    assign padding_out    = busy_out ? line_out[PadWidth-1:0] : '0;

endmodule

// File: tb/tb_mul_row_sequencer.sv
// Directed bench for mul_row_sequencer with a simple accumulator flush model (WORDS=4, latency 2).
module tb_mul_row_sequencer;

    localparam int WORDS = 4;

    logic       clk;
    logic       rst_in, start_in, store_ready_in, store_valid_in, stall_in;
    logic [1:0] a_addr_out, b_addr_out;
    logic       word_valid_out, busy_out, done_out;
    logic [8:0] padding_out;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    logic [1:0] a_p1 = '0, a_p2 = '0, b_p1 = '0, b_p2 = '0;
    int rows, total, done_cnt, done_c, drop_c, busy_gap, bubbles, first_valid_c;
    int start_c, ready_c, gate_bad;

    mul_row_sequencer #(
        .REGISTER_SIZE (32),
        .NUM_BITS      (128),
        .DESIRED_SIZE  (160),
        .READ_LATENCY  (2)
    ) dut (
        .clk_in         (clk),
        .rst_in         (rst_in),
        .start_in       (start_in),
        .store_ready_in (store_ready_in),
        .store_valid_in (store_valid_in),
        .stall_in       (stall_in),
        .a_addr_out     (a_addr_out),
        .b_addr_out     (b_addr_out),
        .word_valid_out (word_valid_out),
        .padding_out    (padding_out),
        .busy_out       (busy_out),
        .done_out       (done_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge, keeping a two-deep history of issued addresses
    task automatic tick();
        a_p2 = a_p1;
        b_p2 = b_p1;
        a_p1 = a_addr_out;
        b_p1 = b_addr_out;
        @(negedge clk);
        cyc++;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk(a_addr_out, 0, {tag, "_a_addr"});
        chk(b_addr_out, 0, {tag, "_b_addr"});
        chk(word_valid_out, 0, {tag, "_valid"});
        chk(padding_out, 0, {tag, "_padding"});
        chk(busy_out, 0, {tag, "_busy"});
        chk(done_out, 0, {tag, "_done"});
    endtask

    task automatic run_to_done(input bit hold_start, input bit abort_mid, input bit do_stall);
        int row_words  = 0;
        int flush_left = 0;
        int stall_left = 0;
        bit stall_used = 0;
        rows = 0; total = 0; done_cnt = 0; done_c = -1; drop_c = -1;
        busy_gap = 0; bubbles = 0; first_valid_c = -1;
        for (int c = 0; c < 600; c++) begin
            tick();
            if (done_out) begin
                done_cnt++;
                if (done_cnt == 1) done_c = cyc;
            end
            if (done_cnt == 0 && !busy_out) busy_gap++;
            if (word_valid_out) begin
                if (first_valid_c < 0) first_valid_c = cyc;
                chk(padding_out, rows, "word_padding");
                chk(a_p2, row_words, "word_a_addr");
                chk(b_p2, rows, "word_b_addr");
                row_words++;
                total++;
                if (row_words == WORDS) begin
                    row_words  = 0;
                    rows++;
                    flush_left = 10;
                end
            end else if (row_words > 0) begin
                bubbles++;
            end
            if (abort_mid && a_addr_out == 2'd1 && b_addr_out == 2'd2) begin
                rst_in         = 1'b1;
                store_valid_in = 1'b0;
                return;
            end
            if (do_stall && !stall_used && a_addr_out == 2'd2 && b_addr_out == 2'd1) begin
                stall_used = 1;
                stall_left = 3;
            end
            stall_in = (stall_left > 0);
            if (stall_left > 0) stall_left--;
            if (flush_left > 0) begin
                store_valid_in = 1'b1;
                flush_left--;
            end else begin
                if (store_valid_in) drop_c = cyc;
                store_valid_in = 1'b0;
            end
            if (hold_start && done_cnt > 0 && cyc == done_c + 1) start_in = 1'b0;
            if (done_cnt > 0 && cyc >= done_c + 2) break;
        end
    endtask

    task automatic chk_run(input string tag, input int exp_bubbles);
        chk(total, WORDS * WORDS, {tag, "_total_words"});
        chk(rows, WORDS, {tag, "_rows"});
        chk(done_cnt, 1, {tag, "_done_pulses"});
        chk(done_c, drop_c + 1, {tag, "_done_timing"});
        chk(busy_gap, 0, {tag, "_busy_gap"});
        chk(bubbles, exp_bubbles, {tag, "_bubbles"});
    endtask

    initial begin
        rst_in = 1'b1; start_in = 1'b0; store_ready_in = 1'b1;
        store_valid_in = 1'b0; stall_in = 1'b0;
        tick();
        tick();
        chk_idle_outputs("reset");
        rst_in = 1'b0;
        tick();
        chk(busy_out, 0, "idle_no_start");

        // Basic run with first-word latency
        start_in = 1'b1;
        start_c  = cyc;
        tick();
        start_in = 1'b0;
        chk(busy_out, 1, "basic_busy_after_start");
        run_to_done(1'b0, 1'b0, 1'b0);
        chk_run("basic", 0);
        chk(first_valid_c, start_c + 4, "basic_first_valid_latency");
        chk(busy_out, 0, "basic_idle_after_done");

        // Ready gating
        store_ready_in = 1'b0;
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
        gate_bad = 0;
        repeat (20) begin
            tick();
            if (a_addr_out != 2'd0 || word_valid_out || !busy_out) gate_bad++;
        end
        chk(gate_bad, 0, "gate_hold");
        store_ready_in = 1'b1;
        ready_c = cyc;
        tick();
        chk(a_addr_out, 0, "gate_first_issue_addr");
        tick();
        chk(a_addr_out, 1, "gate_addr_advance");
        run_to_done(1'b0, 1'b0, 1'b0);
        chk_run("gate", 0);
        chk(first_valid_c, ready_c + 3, "gate_first_valid");

        // Start held high for the whole run
        start_in = 1'b1;
        tick();
        run_to_done(1'b1, 1'b0, 1'b0);
        chk_run("held_start", 0);
        chk(busy_out, 0, "held_start_no_restart");
        tick();
        chk(busy_out, 0, "held_start_still_idle");

        // Reset during row 2 issue
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
        run_to_done(1'b0, 1'b1, 1'b0);
        chk(rows, 2, "abort_row");
        tick();
        chk_idle_outputs("abort");
        rst_in = 1'b0;
        tick();
        chk(word_valid_out, 0, "abort_valid_flushed");
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
        run_to_done(1'b0, 1'b0, 1'b0);
        chk_run("fresh", 0);

        // Stall at row 1, i=2 (ignored unless the stall option is built in)
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
        run_to_done(1'b0, 1'b0, 1'b1);
`ifdef MUL_SEQ_STALL_EN
        chk_run("stall", 3);
`else
        chk_run("stall_ignored", 0);
`endif
        stall_in = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
